// File: rtl/nn_layer_sequencer.sv
// Three-layer MLP control sequencer: walks CLEAR/MAC/DRAIN/STORE per neuron and tracks the layer-2 argmax.
// Optional: define NN_SEQ_ABORT_EN to add an `abort` input that returns any active run to IDLE.
module nn_layer_sequencer #(
    parameter int IN_DIM  = 784,
    parameter int H1_DIM  = 64,
    parameter int H2_DIM  = 32,
    parameter int OUT_DIM = 10,
    parameter int WA_W    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic signed [31:0]  acc_in,
`ifdef NN_SEQ_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy,
    output logic                done,
    output logic [3:0]          state,
    output logic [1:0]          layer,
    output logic [9:0]          in_idx,
    output logic [9:0]          out_idx,
    output logic [WA_W-1:0]     wt_addr,
    output logic                mac_clear,
    output logic                mac_en,
    output logic                wr_en,
    output logic                relu_en,
    output logic [3:0]          argmax_out
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLEAR = 4'd1,
        S_MAC   = 4'd2,
        S_DRAIN = 4'd3,
        S_STORE = 4'd4,
        S_DONE  = 4'd5
    } state_t;

    localparam logic [9:0] IN_N  = 10'(IN_DIM);
    localparam logic [9:0] H1_N  = 10'(H1_DIM);
    localparam logic [9:0] H2_N  = 10'(H2_DIM);
    localparam logic [9:0] OUT_N = 10'(OUT_DIM);

    state_t               state_q, state_d;
    logic [1:0]           layer_q, layer_d;
    logic [9:0]           in_idx_q, in_idx_d;
    logic [9:0]           out_idx_q, out_idx_d;
    logic [WA_W-1:0]      wt_addr_q, wt_addr_d;
    logic                 mac_en_q, mac_en_d;
    logic signed [31:0]   max_val_q, max_val_d;
    logic [3:0]           max_idx_q, max_idx_d;
    logic                 max_vld_q, max_vld_d;
    logic [3:0]           argmax_q, argmax_d;
    logic [9:0]           n_in, n_out;
    logic                 abort_req;

`ifdef NN_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        n_in  = H2_N;
        n_out = OUT_N;
        case (layer_q)
            2'd0: begin n_in = IN_N; n_out = H1_N; end
            2'd1: begin n_in = H1_N; n_out = H2_N; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        wt_addr_d = wt_addr_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        max_vld_d = max_vld_q;
        argmax_d  = argmax_q;
        // Weight data arrives one cycle after its address, so accumulate lags MAC by one.
        mac_en_d  = (state_q == S_MAC);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CLEAR;
                    layer_d   = '0;
                    in_idx_d  = '0;
                    out_idx_d = '0;
                    wt_addr_d = '0;
                    max_vld_d = 1'b0;
                end
            end
            S_CLEAR: state_d = S_MAC;
            S_MAC: begin
                wt_addr_d = wt_addr_q + WA_W'(1);
                if (in_idx_q == n_in - 10'd1) state_d = S_DRAIN;
                else                          in_idx_d = in_idx_q + 10'd1;
            end
            S_DRAIN: state_d = S_STORE;
            S_STORE: begin
                if (layer_q == 2'd2 && (!max_vld_q || acc_in > max_val_q)) begin
                    max_val_d = acc_in;
                    max_idx_d = out_idx_q[3:0];
                    max_vld_d = 1'b1;
                end
                if (out_idx_q != n_out - 10'd1) begin
                    out_idx_d = out_idx_q + 10'd1;
                    in_idx_d  = '0;
                    state_d   = S_CLEAR;
                end else if (layer_q != 2'd2) begin
                    layer_d   = layer_q + 2'd1;
                    out_idx_d = '0;
                    in_idx_d  = '0;
                    state_d   = S_CLEAR;
                end else begin
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                argmax_d = max_idx_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_req && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            mac_en_d = 1'b0;
            argmax_d = argmax_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            layer_q   <= '0;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            wt_addr_q <= '0;
            mac_en_q  <= 1'b0;
            max_val_q <= '0;
            max_idx_q <= '0;
            max_vld_q <= 1'b0;
            argmax_q  <= '0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            wt_addr_q <= wt_addr_d;
            mac_en_q  <= mac_en_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            max_vld_q <= max_vld_d;
            argmax_q  <= argmax_d;
        end
    end

    assign state      = state_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign layer      = layer_q;
    assign in_idx     = in_idx_q;
    assign out_idx    = out_idx_q;
    assign wt_addr    = wt_addr_q;
    assign mac_clear  = (state_q == S_CLEAR);
    assign mac_en     = mac_en_q;
    assign wr_en      = (state_q == S_STORE);
    assign relu_en    = (state_q == S_STORE) && (layer_q != 2'd2);
    assign argmax_out = argmax_q;

endmodule
